raster_timing_gen: RTL and testbench

- Video raster timing stage built on cascaded 4-bit load/count cells.
- Consumes the counter carry chain and turns it into a 9-bit horizontal pixel counter and a 9-bit vertical line counter.
- Produces registered sync, blank and line-start strobes for the sprite/fix pipeline and video output.
- Both counters count up to all-ones and then reload a start value, so period = 512 - start.

---
 rtl/raster_pkg.sv | 20 ++
 rtl/raster_cnt9.sv | 27 ++
 rtl/raster_timing_gen.sv | 83 ++++++++
 tb/tb_raster_timing_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared raster timing constants and the 9-bit count type.
package raster_pkg;

  localparam int unsigned CNT_W = 9;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t DEF_H_START     = 9'h080;
  localparam count_t DEF_H_SYNC_END  = 9'h0A0;
  localparam count_t DEF_H_VIS_START = 9'h0C0;
  localparam count_t DEF_V_START     = 9'h0F8;
  localparam count_t DEF_V_SYNC_END  = 9'h100;
  localparam count_t DEF_V_VIS_START = 9'h110;
  localparam count_t DEF_V_VIS_END   = 9'h1F0;

  // Counters run from the start value up to all-ones, so period = 512 - start.
  localparam int unsigned H_TOTAL = 512 - int'(DEF_H_START);
  localparam int unsigned V_TOTAL = 512 - int'(DEF_V_START);

endpackage

// File: rtl/raster_cnt9.sv
// 9-bit load/count cell: counts on carry-in, reloads START after all-ones.
module raster_cnt9
  import raster_pkg::*;
#(
  parameter count_t START = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ci,
  output logic [8:0] q,
  output logic [8:0] nxt_c,
  output logic       co_c
);

  assign co_c = ci && (q == 9'h1FF);

  always_comb begin
    nxt_c = q;
    if (ci) nxt_c = co_c ? START : count_t'(q + 9'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= START;
    else        q <= nxt_c;
  end

endmodule

// File: rtl/raster_timing_gen.sv
// Raster timing: cascaded H/V counters with registered sync, blank and strobes.
// Optional line interrupt enabled by defining RASTER_LINE_IRQ_EN.
module raster_timing_gen
  import raster_pkg::*;
#(
  parameter count_t H_START     = DEF_H_START,
  parameter count_t H_SYNC_END  = DEF_H_SYNC_END,
  parameter count_t H_VIS_START = DEF_H_VIS_START,
  parameter count_t V_START     = DEF_V_START,
  parameter count_t V_SYNC_END  = DEF_V_SYNC_END,
  parameter count_t V_VIS_START = DEF_V_VIS_START,
  parameter count_t V_VIS_END   = DEF_V_VIS_END
) (
  input  logic       CK,
  input  logic       nCL,
  input  logic       CE,
`ifdef RASTER_LINE_IRQ_EN
  input  logic [8:0] IRQ_LINE,
  output logic       nLINE_IRQ,
`endif
  output logic [8:0] H_CNT,
  output logic [8:0] V_CNT,
  output logic       nHSYNC,
  output logic       nVSYNC,
  output logic       nHBLANK,
  output logic       nVBLANK,
  output logic       LINE_START,
  output logic       FRAME_START
);

  count_t h_nxt;
  count_t v_nxt;
  logic   hc;
  logic   vc;

  raster_cnt9 #(.START(H_START)) u_hcnt (
    .clk   (CK),
    .rst_n (nCL),
    .ci    (CE),
    .q     (H_CNT),
    .nxt_c (h_nxt),
    .co_c  (hc)
  );

  raster_cnt9 #(.START(V_START)) u_vcnt (
    .clk   (CK),
    .rst_n (nCL),
    .ci    (hc),
    .q     (V_CNT),
    .nxt_c (v_nxt),
    .co_c  (vc)
  );

  // Decode from the next count so the registered flags line up with the counters.
  always_ff @(posedge CK or negedge nCL) begin
    if (!nCL) begin
      nHSYNC      <= 1'b0;
      nVSYNC      <= 1'b0;
      nHBLANK     <= 1'b0;
      nVBLANK     <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      LINE_START  <= hc;
      FRAME_START <= hc && vc;
      if (CE) begin
        nHSYNC  <= !(h_nxt < H_SYNC_END);
        nHBLANK <= !(h_nxt < H_VIS_START);
        nVSYNC  <= !(v_nxt < V_SYNC_END);
        nVBLANK <= !((v_nxt < V_VIS_START) || (v_nxt >= V_VIS_END));
      end
    end
  end

`ifdef RASTER_LINE_IRQ_EN
  // Lines outside the counted range can never match, so no IRQ fires for them.
  always_ff @(posedge CK or negedge nCL) begin
    if (!nCL) nLINE_IRQ <= 1'b1;
    else      nLINE_IRQ <= !(hc && (v_nxt == IRQ_LINE) && (IRQ_LINE >= V_START));
  end
`endif

endmodule

// File: tb/tb_raster_timing_gen.sv
// Directed bench for raster_timing_gen: a default-timing instance plus a short-line
// instance (8 pixels per line) so whole frames fit in a short run.
module tb_raster_timing_gen;

  logic       CK, nCL, CE;
  logic [8:0] h_cnt, v_cnt, sh_cnt, sv_cnt;
  logic       n_hsync, n_vsync, n_hblank, n_vblank, line_start, frame_start;
  logic       s_n_hsync, s_n_vsync, s_n_hblank, s_n_vblank, s_line_start, s_frame_start;
`ifdef RASTER_LINE_IRQ_EN
  logic [8:0] irq_line, s_irq_line;
  logic       n_irq, s_n_irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  raster_timing_gen dut (
    .CK(CK), .nCL(nCL), .CE(CE),
`ifdef RASTER_LINE_IRQ_EN
    .IRQ_LINE(irq_line), .nLINE_IRQ(n_irq),
`endif
    .H_CNT(h_cnt), .V_CNT(v_cnt), .nHSYNC(n_hsync), .nVSYNC(n_vsync),
    .nHBLANK(n_hblank), .nVBLANK(n_vblank), .LINE_START(line_start),
    .FRAME_START(frame_start)
  );

  raster_timing_gen #(
    .H_START(9'h1F8), .H_SYNC_END(9'h1FA), .H_VIS_START(9'h1FC)
  ) dut_s (
    .CK(CK), .nCL(nCL), .CE(CE),
`ifdef RASTER_LINE_IRQ_EN
    .IRQ_LINE(s_irq_line), .nLINE_IRQ(s_n_irq),
`endif
    .H_CNT(sh_cnt), .V_CNT(sv_cnt), .nHSYNC(s_n_hsync), .nVSYNC(s_n_vsync),
    .nHBLANK(s_n_hblank), .nVBLANK(s_n_vblank), .LINE_START(s_line_start),
    .FRAME_START(s_frame_start)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic step(input logic ce_v);
    CE = ce_v;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    nCL = 1'b0;
    repeat (3) step(1'b1);
    n_cmp++; if (h_cnt !== 9'h080) begin n_bad++; $display("FAIL reset_h: got %h expected 080", h_cnt); end
    n_cmp++; if (v_cnt !== 9'h0F8) begin n_bad++; $display("FAIL reset_v: got %h expected 0f8", v_cnt); end
    n_cmp++;
    if ({n_hsync, n_vsync, n_hblank, n_vblank, line_start, frame_start} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000000",
               {n_hsync, n_vsync, n_hblank, n_vblank, line_start, frame_start});
    end
    n_cmp++; if (sh_cnt !== 9'h1F8) begin n_bad++; $display("FAIL reset_short_h: got %h expected 1f8", sh_cnt); end
`ifdef RASTER_LINE_IRQ_EN
    n_cmp++; if (n_irq !== 1'b1) begin n_bad++; $display("FAIL reset_irq: got %b expected 1", n_irq); end
`endif
    nCL = 1'b1;
    step(1'b1);
    n_cmp++; if (h_cnt !== 9'h081) begin n_bad++; $display("FAIL release_h: got %h expected 081", h_cnt); end
    n_cmp++; if (v_cnt !== 9'h0F8) begin n_bad++; $display("FAIL release_v: got %h expected 0f8", v_cnt); end
  endtask

  task automatic test_line_wrap();
    repeat (382) step(1'b1);
    n_cmp++; if (h_cnt !== 9'h1FF) begin n_bad++; $display("FAIL wrap_pre_h: got %h expected 1ff", h_cnt); end
    n_cmp++; if (v_cnt !== 9'h0F8) begin n_bad++; $display("FAIL wrap_pre_v: got %h expected 0f8", v_cnt); end
    n_cmp++; if ({n_hsync, n_hblank, line_start} !== 3'b110) begin n_bad++; $display("FAIL wrap_pre_flags: got %b expected 110", {n_hsync, n_hblank, line_start}); end
    step(1'b1);
    n_cmp++; if (h_cnt !== 9'h080) begin n_bad++; $display("FAIL wrap_h: got %h expected 080", h_cnt); end
    n_cmp++; if (v_cnt !== 9'h0F9) begin n_bad++; $display("FAIL wrap_v: got %h expected 0f9", v_cnt); end
    n_cmp++; if ({n_hsync, n_hblank, line_start, frame_start} !== 4'b0010) begin n_bad++; $display("FAIL wrap_flags: got %b expected 0010", {n_hsync, n_hblank, line_start, frame_start}); end
    step(1'b1);
    n_cmp++; if (line_start !== 1'b0) begin n_bad++; $display("FAIL wrap_pulse_width: got %b expected 0", line_start); end
    n_cmp++; if (h_cnt !== 9'h081) begin n_bad++; $display("FAIL wrap_post_h: got %h expected 081", h_cnt); end
  endtask

  task automatic test_h_decode();
    int ns = 0, nb = 0, nl = 0, bad = 0;
    repeat (384) begin
      step(1'b1);
      if (!n_hsync) ns++;
      if (!n_hblank) nb++;
      if (line_start) nl++;
      if ((n_hsync !== (h_cnt >= 9'h0A0)) || (n_hblank !== (h_cnt >= 9'h0C0))) bad++;
    end
    n_cmp++; if (ns != 32) begin n_bad++; $display("FAIL hsync_len: got %0d expected 32", ns); end
    n_cmp++; if (nb != 64) begin n_bad++; $display("FAIL hblank_len: got %0d expected 64", nb); end
    n_cmp++; if (nl != 1) begin n_bad++; $display("FAIL line_start_count: got %0d expected 1", nl); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL h_decode_align: got %0d bad samples expected 0", bad); end
    n_cmp++; if ({h_cnt, v_cnt} !== {9'h081, 9'h0FA}) begin n_bad++; $display("FAIL h_decode_end: got %h/%h expected 081/0fa", h_cnt, v_cnt); end
  endtask

  task automatic test_gating();
    int k = 0, bad = 0;
    while (h_cnt !== 9'h123 && k < 400) begin
      step(1'b1);
      k++;
    end
    n_cmp++; if (h_cnt !== 9'h123) begin n_bad++; $display("FAIL gate_reach: got %h expected 123", h_cnt); end
    repeat (50) begin
      step(1'b0);
      if (h_cnt !== 9'h123 || v_cnt !== 9'h0FA ||
          {n_hsync, n_vsync, n_hblank, n_vblank} !== 4'b1010 ||
          line_start !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL gate_hold: got %0d bad samples expected 0", bad); end
    step(1'b1);
    n_cmp++; if (h_cnt !== 9'h124) begin n_bad++; $display("FAIL gate_resume: got %h expected 124", h_cnt); end
  endtask

  task automatic test_frame();
    int fs = 0, fs_idx = -1, fs_pos_bad = 0, vs = 0, vb = 0, ls = 0, bad = 0, dfs = 0;
`ifdef RASTER_LINE_IRQ_EN
    int irq = 0, irq_pos_bad = 0, dirq = 0;
`endif
    nCL = 1'b0;
    step(1'b1);
    nCL = 1'b1;
    n_cmp++; if ({sh_cnt, sv_cnt} !== {9'h1F8, 9'h0F8}) begin n_bad++; $display("FAIL frame_start_state: got %h/%h expected 1f8/0f8", sh_cnt, sv_cnt); end
    for (int i = 0; i < 2112; i++) begin
      step(1'b1);
      if (s_frame_start) begin
        fs++;
        fs_idx = i;
        if (sh_cnt !== 9'h1F8 || sv_cnt !== 9'h0F8) fs_pos_bad++;
      end
      if (frame_start) dfs++;
      if (!s_n_vsync) vs++;
      if (s_n_vblank) vb++;
      if (s_line_start) ls++;
      if ((s_n_vsync !== (sv_cnt >= 9'h100)) ||
          (s_n_vblank !== (sv_cnt >= 9'h110 && sv_cnt < 9'h1F0))) bad++;
`ifdef RASTER_LINE_IRQ_EN
      if (!s_n_irq) begin
        irq++;
        if (sv_cnt !== 9'h120 || sh_cnt !== 9'h1F8) irq_pos_bad++;
      end
      if (!n_irq) dirq++;
`endif
    end
    n_cmp++; if (fs != 1) begin n_bad++; $display("FAIL frame_start_count: got %0d expected 1", fs); end
    n_cmp++; if (fs_idx != 2111) begin n_bad++; $display("FAIL frame_start_tick: got %0d expected 2111", fs_idx); end
    n_cmp++; if (fs_pos_bad != 0) begin n_bad++; $display("FAIL frame_start_pos: got %0d bad expected 0", fs_pos_bad); end
    n_cmp++; if (vs != 64) begin n_bad++; $display("FAIL vsync_len: got %0d expected 64", vs); end
    n_cmp++; if (vb != 1792) begin n_bad++; $display("FAIL vvisible_len: got %0d expected 1792", vb); end
    n_cmp++; if (ls != 264) begin n_bad++; $display("FAIL lines_per_frame: got %0d expected 264", ls); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL v_decode_align: got %0d bad samples expected 0", bad); end
    n_cmp++; if ({h_cnt, v_cnt} !== {9'h140, 9'h0FD}) begin n_bad++; $display("FAIL default_after_2112: got %h/%h expected 140/0fd", h_cnt, v_cnt); end
    n_cmp++; if (dfs != 0) begin n_bad++; $display("FAIL default_no_frame: got %0d expected 0", dfs); end
`ifdef RASTER_LINE_IRQ_EN
    n_cmp++; if (irq != 1) begin n_bad++; $display("FAIL irq_count: got %0d expected 1", irq); end
    n_cmp++; if (irq_pos_bad != 0) begin n_bad++; $display("FAIL irq_pos: got %0d bad expected 0", irq_pos_bad); end
    n_cmp++; if (dirq != 0) begin n_bad++; $display("FAIL irq_out_of_range: got %0d expected 0", dirq); end
`endif
  endtask

  task automatic test_mid_reset();
    int k = 0;
    while (sv_cnt !== 9'h150 && k < 1000) begin
      step(1'b1);
      k++;
    end
    n_cmp++; if ({sv_cnt, s_n_vblank, s_line_start} !== {9'h150, 2'b11}) begin n_bad++; $display("FAIL midreset_reach: got %h/%b%b expected 150/11", sv_cnt, s_n_vblank, s_line_start); end
    nCL = 1'b0;
    #1;
    n_cmp++; if ({sh_cnt, sv_cnt} !== {9'h1F8, 9'h0F8}) begin n_bad++; $display("FAIL midreset_counts: got %h/%h expected 1f8/0f8", sh_cnt, sv_cnt); end
    n_cmp++;
    if ({s_n_hsync, s_n_vsync, s_n_hblank, s_n_vblank, s_line_start, s_frame_start} !== 6'b0) begin
      n_bad++;
      $display("FAIL midreset_flags: got %b expected 000000",
               {s_n_hsync, s_n_vsync, s_n_hblank, s_n_vblank, s_line_start, s_frame_start});
    end
    n_cmp++; if ({h_cnt, v_cnt} !== {9'h080, 9'h0F8}) begin n_bad++; $display("FAIL midreset_default: got %h/%h expected 080/0f8", h_cnt, v_cnt); end
    step(1'b1);
    nCL = 1'b1;
    step(1'b1);
    n_cmp++; if ({sh_cnt, h_cnt} !== {9'h1F9, 9'h081}) begin n_bad++; $display("FAIL midreset_resume: got %h/%h expected 1f9/081", sh_cnt, h_cnt); end
  endtask

  initial begin
    nCL = 1'b0;
    CE  = 1'b0;
`ifdef RASTER_LINE_IRQ_EN
    irq_line   = 9'h0F0;
    s_irq_line = 9'h120;
`endif
    test_reset();
    test_line_wrap();
    test_h_decode();
    test_gating();
    test_frame();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
